// File: rtl/sop_share_eval.sv
// Configurable sum-of-products evaluator with shared product terms, a two-stage
// valid/ready pipeline and an error monitor that compares the result against a+b.
module sop_share_eval #(
  parameter int          N_IN   = 4,
  parameter int          N_OUT  = 3,
  parameter int          N_PR   = 5,
  parameter int unsigned ET     = 1,
  localparam int         ADDR_W = $clog2(N_PR + N_OUT),
  localparam int         DATA_W = (2 * N_IN > N_PR) ? 2 * N_IN : N_PR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_req,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_data,
  output logic              err_flag,
  output logic [15:0]       err_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CFG   = 2'd2;
  localparam int         HALF     = N_IN / 2;

  logic [1:0]        state_reg, state_next;
  logic [2*N_IN-1:0] prod_cfg_reg [N_PR];
  logic [N_PR-1:0]   act_cfg_reg  [N_OUT];

  logic              v1_reg;
  logic [N_PR-1:0]   prod_reg;
  logic [N_OUT-1:0]  sum1_reg;
  logic              out_valid_reg;
  logic [N_OUT-1:0]  out_data_reg;
  logic [N_OUT-1:0]  exact_reg;
  logic [15:0]       err_cnt_reg;

  logic              en, in_fire, out_fire, cfg_wr, cfg_entry;
  logic [N_PR-1:0]   prod_vec;
  logic [N_OUT-1:0]  sop_vec, sum_vec, diff_vec;

  assign en        = !out_valid_reg || out_ready;
  assign in_ready  = rst_n && (state_reg == ST_RUN) && en;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_reg && out_ready;
  assign cfg_wr    = cfg_we && (state_reg == ST_CFG);
  assign cfg_entry = (state_reg != ST_CFG) && (state_next == ST_CFG);
  assign cfg_mode  = (state_reg == ST_CFG);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:   if (cfg_req) state_next = ST_DRAIN;
      ST_DRAIN: if (!v1_reg && !out_valid_reg) state_next = ST_CFG;
      ST_CFG:   if (cfg_commit) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_RUN;
    else        state_reg <= state_next;
  end

  // Addresses past the last activation word match no entry, so they fall away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < N_PR; p++)  prod_cfg_reg[p] <= '1;
      for (int k = 0; k < N_OUT; k++) act_cfg_reg[k]  <= '0;
    end else if (cfg_wr) begin
      for (int p = 0; p < N_PR; p++)
        if (cfg_addr == ADDR_W'(p)) prod_cfg_reg[p] <= cfg_data[2*N_IN-1:0];
      for (int k = 0; k < N_OUT; k++)
        if (cfg_addr == ADDR_W'(N_PR + k)) act_cfg_reg[k] <= cfg_data[N_PR-1:0];
    end
  end

  // Each product is evaluated once; every output ORs from the same vector.
  for (genvar gi = 0; gi < N_PR; gi++) begin : g_prod
    logic [N_IN-1:0] lit;
    for (genvar gj = 0; gj < N_IN; gj++) begin : g_lit
      logic [1:0] fld;
      assign fld     = prod_cfg_reg[gi][2*gj +: 2];
      assign lit[gj] = (fld == 2'b00) || ((fld == 2'b01) && in_data[gj])
                    || ((fld == 2'b10) && !in_data[gj]);
    end
    assign prod_vec[gi] = &lit;
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_sop
    assign sop_vec[gi] = |(prod_reg & act_cfg_reg[gi]);
  end

  assign sum_vec = N_OUT'(in_data[HALF-1:0]) + N_OUT'(in_data[N_IN-1:HALF]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg        <= 1'b0;
      prod_reg      <= '0;
      sum1_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      exact_reg     <= '0;
    end else if (en) begin
      v1_reg        <= in_fire;
      out_valid_reg <= v1_reg;
      if (in_fire) begin
        prod_reg <= prod_vec;
        sum1_reg <= sum_vec;
      end
      if (v1_reg) begin
        out_data_reg <= sop_vec;
        exact_reg    <= sum1_reg;
      end
    end
  end

  // The flag is a pure function of the stage-2 registers, so it holds under stall.
  assign diff_vec = (out_data_reg >= exact_reg) ? (out_data_reg - exact_reg)
                                                : (exact_reg - out_data_reg);
  assign err_flag = 32'(diff_vec) > ET;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_reg <= '0;
    else if (cfg_entry)
      err_cnt_reg <= '0;
    else if (out_fire && err_flag && (err_cnt_reg != 16'hFFFF))
      err_cnt_reg <= err_cnt_reg + 16'd1;
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign err_cnt   = err_cnt_reg;

endmodule
